// File: rtl/xpb_pkg.sv
// xpb_pkg: shared state type, default geometry and segment helpers for xpb_lut_accum.
package xpb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} xpb_state_e;

  localparam int unsigned XPB_SEG_BITS_DEF  = 5;
  localparam int unsigned XPB_NUM_SEGS_DEF  = 4;
  localparam int unsigned XPB_WORD_BITS_DEF = 1024;
  localparam int unsigned XPB_SEG_CNT_W_DEF = $clog2(XPB_NUM_SEGS_DEF);
  localparam int unsigned XPB_SUM_BITS_DEF  = XPB_WORD_BITS_DEF + XPB_SEG_CNT_W_DEF;

  // Widest packed index word the extract helper accepts.
  localparam int unsigned XPB_EXT_W = 1024;

  function automatic int unsigned xpb_sum_bits(input int unsigned word_bits,
                                               input int unsigned num_segs);
    return word_bits + $clog2(num_segs);
  endfunction

  function automatic logic [31:0] xpb_seg_extract(input logic [XPB_EXT_W-1:0] data,
                                                  input int unsigned         seg,
                                                  input int unsigned         seg_bits);
    return 32'(data >> (seg * seg_bits)) & ((32'd1 << seg_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/xpb_table_ram.sv
// xpb_table_ram: simple dual-port table with synchronous read; only the read register resets.
module xpb_table_ram #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned DATA_BITS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-edge read returns the old entry.
  always_ff @(posedge clk_i) begin
    if (reset_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xpb_lut_accum.sv
// xpb_lut_accum: loadable per-segment reduction tables with sequential carry-extended accumulation.
// Define XPB_SKIP_ZERO_EN to visit only segments whose index is nonzero.
module xpb_lut_accum
  import xpb_pkg::*;
#(
  parameter  int unsigned SEG_BITS  = XPB_SEG_BITS_DEF,
  parameter  int unsigned NUM_SEGS  = XPB_NUM_SEGS_DEF,
  parameter  int unsigned WORD_BITS = XPB_WORD_BITS_DEF,
  localparam int unsigned SEG_W     = $clog2(NUM_SEGS),
  localparam int unsigned SUM_BITS  = xpb_sum_bits(WORD_BITS, NUM_SEGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tbl_we,
  input  logic [SEG_W-1:0]             tbl_seg,
  input  logic [SEG_BITS-1:0]          tbl_idx,
  input  logic [WORD_BITS-1:0]         tbl_data,
  output logic                         tbl_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SEGS*SEG_BITS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_BITS-1:0]          out_data
);

  localparam int unsigned IN_W = NUM_SEGS * SEG_BITS;

  xpb_state_e           state_q;
  logic [IN_W-1:0]      in_q;
  logic [SUM_BITS-1:0]  acc_q, acc_d;
  logic [SEG_W-1:0]     sel_q, cur_seg;
  logic                 rvalid_q, out_valid_q, tbl_err_q;
  logic                 last_seg, accept;
  logic [NUM_SEGS-1:0]  conflict_q, conflict_now, re;
  logic [SEG_BITS-1:0]  idx_in [NUM_SEGS];
  logic [SEG_BITS-1:0]  idx_q  [NUM_SEGS];
  logic [WORD_BITS-1:0] rdata  [NUM_SEGS];

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign tbl_err   = tbl_err_q;

  // A write landing on the very entry an accepted word will read is pre-read on the
  // acceptance edge (old data) and that table's later RUN read is suppressed.
  for (genvar s = 0; s < NUM_SEGS; s++) begin : g_seg
    assign idx_in[s] = SEG_BITS'(xpb_seg_extract(XPB_EXT_W'(in_data), s, SEG_BITS));
    assign idx_q[s]  = SEG_BITS'(xpb_seg_extract(XPB_EXT_W'(in_q), s, SEG_BITS));
    assign conflict_now[s] = tbl_we && (tbl_seg == SEG_W'(s)) && (idx_in[s] == tbl_idx);
    assign re[s] = (accept && conflict_now[s]) ||
                   ((state_q == RUN) && (cur_seg == SEG_W'(s)) && !conflict_q[s]);

    xpb_table_ram #(
      .ADDR_BITS(SEG_BITS),
      .DATA_BITS(WORD_BITS)
    ) u_ram (
      .clk_i   (clk),
      .reset_i (reset),
      .we_i    (tbl_we && (state_q == IDLE) && (tbl_seg == SEG_W'(s))),
      .waddr_i (tbl_idx),
      .wdata_i (tbl_data),
      .re_i    (re[s]),
      .raddr_i (accept ? idx_in[s] : idx_q[s]),
      .rdata_o (rdata[s])
    );
  end

`ifdef XPB_SKIP_ZERO_EN
  logic [NUM_SEGS-1:0] mask_q, mask_left, nz_in;

  for (genvar s = 0; s < NUM_SEGS; s++) begin : g_nz
    assign nz_in[s] = |idx_in[s];
  end

  always_comb begin
    cur_seg = '0;
    for (int unsigned i = NUM_SEGS; i > 0; i--) begin
      if (mask_q[i-1]) cur_seg = SEG_W'(i-1);
    end
    mask_left = mask_q & ~(NUM_SEGS'(1) << cur_seg);
    last_seg  = (mask_left == '0);
  end
`else
  logic [SEG_W-1:0] seg_q;

  assign cur_seg  = seg_q;
  assign last_seg = (seg_q == SEG_W'(NUM_SEGS-1));
`endif

  always_comb begin
    acc_d = acc_q;
    if (rvalid_q) acc_d = acc_q + SUM_BITS'(rdata[sel_q]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sel_q       <= '0;
      rvalid_q    <= 1'b0;
      out_valid_q <= 1'b0;
      tbl_err_q   <= 1'b0;
      conflict_q  <= '0;
`ifdef XPB_SKIP_ZERO_EN
      mask_q      <= '0;
`else
      seg_q       <= '0;
`endif
    end else begin
      tbl_err_q <= tbl_we && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            in_q       <= in_data;
            acc_q      <= '0;
            rvalid_q   <= 1'b0;
            conflict_q <= conflict_now;
`ifdef XPB_SKIP_ZERO_EN
            mask_q     <= nz_in;
            state_q    <= (nz_in == '0) ? DRAIN : RUN;
`else
            seg_q      <= '0;
            state_q    <= RUN;
`endif
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          rvalid_q <= 1'b1;
          sel_q    <= cur_seg;
`ifdef XPB_SKIP_ZERO_EN
          mask_q   <= mask_left;
`else
          seg_q    <= seg_q + SEG_W'(1);
`endif
          if (last_seg) state_q <= DRAIN;
        end
        DRAIN: begin
          acc_q       <= acc_d;
          rvalid_q    <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_lut_accum.sv
// Directed scoreboard bench for xpb_lut_accum; expectations follow XPB_SKIP_ZERO_EN when defined.
module tb_xpb_lut_accum;
  import xpb_pkg::*;

  localparam int unsigned SB = 5;
  localparam int unsigned NS = 4;
  localparam int unsigned WB = 1024;
  localparam int unsigned CW = XPB_SEG_CNT_W_DEF;
  localparam int unsigned SW = XPB_SUM_BITS_DEF;

  typedef logic [SW-1:0]    sum_t;
  typedef logic [NS*SB-1:0] word_t;
  typedef struct {
    sum_t            sum;
    int unsigned     lat;
    longint unsigned acc_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tbl_we = 1'b0;
  logic [CW-1:0] tbl_seg = '0;
  logic [SB-1:0] tbl_idx = '0;
  logic [WB-1:0] tbl_data = '0;
  logic          tbl_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  word_t         in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  sum_t          out_data;

  xpb_lut_accum #(
    .SEG_BITS (SB),
    .NUM_SEGS (NS),
    .WORD_BITS(WB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tbl_we   (tbl_we),
    .tbl_seg  (tbl_seg),
    .tbl_idx  (tbl_idx),
    .tbl_data (tbl_data),
    .tbl_err  (tbl_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WB-1:0] tbl_m [NS][2**SB];
  exp_t          sb[$];
  int unsigned   total = 0;
  int unsigned   bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input sum_t got, input sum_t want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got_hi=%h got_lo=%h want_hi=%h want_lo=%h",
             tag, got[SW-1:SW-16], got[63:0], want[SW-1:SW-16], want[63:0]);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  function automatic word_t pk(input int a, input int b, input int c, input int d);
    return {SB'(d), SB'(c), SB'(b), SB'(a)};
  endfunction

  function automatic sum_t model_sum(input word_t w);
    sum_t          s;
    logic [SB-1:0] ix;
    s = '0;
    for (int k = 0; k < NS; k++) begin
      ix = w[k*SB +: SB];
`ifdef XPB_SKIP_ZERO_EN
      if (ix == '0) continue;
`endif
      s += {{(SW-WB){1'b0}}, tbl_m[k][ix]};
    end
    return s;
  endfunction

  function automatic int unsigned model_lat(input word_t w);
`ifdef XPB_SKIP_ZERO_EN
    int unsigned k;
    k = 0;
    for (int i = 0; i < NS; i++) if (w[i*SB +: SB] != '0) k++;
    return k + 1;
`else
    return (w == '0) ? NS + 1 : NS + 1;
`endif
  endfunction

  task automatic wr(input int s, input int i, input logic [WB-1:0] d);
    tbl_we   = 1'b1;
    tbl_seg  = CW'(s);
    tbl_idx  = SB'(i);
    tbl_data = d;
    tick();
    tbl_we = 1'b0;
    tbl_m[s][i] = d;
  endtask

  // Drives one word (optionally with a same-edge table write) and queues its expectation.
  task automatic send(input word_t w, input bit do_wr, input int ws, input int wi,
                      input logic [WB-1:0] wd);
    exp_t        e;
    int unsigned n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk1("accept_wait", n >= 100, 1'b0);
    if (do_wr) begin
      tbl_we   = 1'b1;
      tbl_seg  = CW'(ws);
      tbl_idx  = SB'(wi);
      tbl_data = wd;
    end
    e.sum = model_sum(w);
    e.lat = model_lat(w);
    tick();
    e.acc_cyc = cyc;
    in_valid  = 1'b0;
    tbl_we    = 1'b0;
    sb.push_back(e);
    if (do_wr) tbl_m[ws][wi] = wd;
  endtask

  task automatic recv(input int unsigned hold, input bit poke);
    exp_t        e;
    int unsigned n;
    n = 0;
    out_ready = (hold == 0);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk1("out_valid_seen", out_valid, 1'b1);
    if (sb.size() == 0) begin
      chk1("sb_nonempty", 1'b0, 1'b1);
      out_ready = 1'b1;
      return;
    end
    e = sb.pop_front();
    chk("sum", out_data, e.sum);
    chk("latency", sum_t'(cyc - e.acc_cyc), sum_t'(e.lat));
    for (int unsigned h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_data  = '1;
      end
      tick();
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, e.sum);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk1("valid_drop", out_valid, 1'b0);
    chk1("ready_back", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk1("rst_tbl_err", tbl_err, 1'b0);

    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 2**SB; i++)
        wr(s, i, WB'((s << 8) | i));
    tick();
    chk1("wr_no_err", tbl_err, 1'b0);

    send(pk(1, 2, 3, 4), 1'b0, 0, 0, '0);
    recv(0, 1'b0);
    chk("basic_sum_const", out_data, sum_t'(12'h60A));

    send(pk(0, 7, 0, 0), 1'b0, 0, 0, '0);
    recv(0, 1'b0);
    send(pk(0, 0, 0, 0), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    // Backpressure with a word waiting on in_valid, then the next word.
    send(pk(5, 6, 7, 8), 1'b0, 0, 0, '0);
    recv(10, 1'b1);
    send(pk(31, 0, 17, 2), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    // Table write during RUN is dropped.
    send(pk(1, 2, 3, 4), 1'b0, 0, 0, '0);
    tick();
    tbl_we   = 1'b1;
    tbl_seg  = CW'(1);
    tbl_idx  = SB'(2);
    tbl_data = WB'(8'hFF);
    tick();
    tbl_we = 1'b0;
    chk1("err_pulse", tbl_err, 1'b1);
    tick();
    chk1("err_clear", tbl_err, 1'b0);
    recv(0, 1'b0);
    send(pk(0, 2, 0, 0), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    // Reset on the second RUN cycle discards the operation.
    send(pk(9, 10, 11, 12), 1'b0, 0, 0, '0);
    tick();
    reset = 1'b1;
    tick();
    chk1("rst_mid_ready_low", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_mid_in_ready", in_ready, 1'b1);
    chk1("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_data", out_data, '0);
    void'(sb.pop_back());
    n = 0;
    repeat (8) begin
      tick();
      if (out_valid) n++;
    end
    chk("rst_mid_quiet", sum_t'(n), '0);
    send(pk(31, 30, 29, 28), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    // Same-edge write and acceptance: lookup sees the old entry, the next one the new.
    send(pk(1, 1, 3, 1), 1'b1, 2, 3, WB'(12'hABC));
    recv(0, 1'b0);
    send(pk(1, 1, 3, 1), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      send(pk($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31)), 1'b0, 0, 0, '0);
      recv($urandom_range(0, 3), 1'b0);
    end

    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 2**SB; i++)
        wr(s, i, '1);
    send(pk(31, 31, 31, 31), 1'b0, 0, 0, '0);
    recv(0, 1'b0);
    send(pk(31, 0, 31, 0), 1'b0, 0, 0, '0);
    recv(0, 1'b0);

    chk("sb_drained", sum_t'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
